mac_key_queue: RTL and testbench



---
 rtl/mac_key_queue.sv | 229 ++++++++++++++++++++++
 tb/tb_mac_key_queue.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_key_queue.sv
// PS/2 key events to Mac 128K transition codes: translate, drop typematic
// repeats, queue the codes, and answer keyboard-link host commands.
module mac_key_queue #(
   parameter int         FIFO_DEPTH  = 8,
   parameter int         INQ_TIMEOUT = 6250000,
   parameter logic [7:0] MODEL_BYTE  = 8'h03
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] ps2_key,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd,
   output logic        resp_valid,
   output logic [7:0]  resp,
   output logic        busy,
   output logic        overrun
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = (INQ_TIMEOUT > 1) ? $clog2(INQ_TIMEOUT) : 1;

   localparam logic [7:0] CMD_INQUIRY = 8'h10;
   localparam logic [7:0] CMD_INSTANT = 8'h14;
   localparam logic [7:0] CMD_MODEL   = 8'h16;
   localparam logic [7:0] CMD_TEST    = 8'h36;
   localparam logic [7:0] RESP_NULL   = 8'h7B;
   localparam logic [7:0] RESP_ACK    = 8'h7D;

   typedef enum logic [1:0] {H_IDLE, H_DECODE, H_WAIT, H_REPLY} state_t;

   // Returns {hit, keycode}; every Mac 128K keycode fits in six bits.
   function automatic logic [6:0] lookup(input logic [8:0] key);
      case (key)
         9'h01C:  lookup = {1'b1, 6'h00};
         9'h01B:  lookup = {1'b1, 6'h01};
         9'h023:  lookup = {1'b1, 6'h02};
         9'h02B:  lookup = {1'b1, 6'h03};
         9'h033:  lookup = {1'b1, 6'h04};
         9'h034:  lookup = {1'b1, 6'h05};
         9'h01A:  lookup = {1'b1, 6'h06};
         9'h022:  lookup = {1'b1, 6'h07};
         9'h021:  lookup = {1'b1, 6'h08};
         9'h02A:  lookup = {1'b1, 6'h09};
         9'h032:  lookup = {1'b1, 6'h0B};
         9'h015:  lookup = {1'b1, 6'h0C};
         9'h01D:  lookup = {1'b1, 6'h0D};
         9'h024:  lookup = {1'b1, 6'h0E};
         9'h02D:  lookup = {1'b1, 6'h0F};
         9'h05A:  lookup = {1'b1, 6'h24};
         9'h029:  lookup = {1'b1, 6'h31};
         9'h066:  lookup = {1'b1, 6'h33};
         9'h012:  lookup = {1'b1, 6'h38};
         9'h059:  lookup = {1'b1, 6'h38};
         9'h014:  lookup = {1'b1, 6'h3A};
         9'h11F:  lookup = {1'b1, 6'h37};
         default: lookup = 7'h00;
      endcase
   endfunction

   logic             vld_p1_q, vld_p1_d;
   logic             pressed_p1_q, pressed_p1_d;
   logic [8:0]       key_p1_q, key_p1_d;
   logic [6:0]       lut_p1;
   logic             vld_p2_q, vld_p2_d;
   logic             pressed_p2_q, pressed_p2_d;
   logic [5:0]       kc_p2_q, kc_p2_d;

   logic [63:0]      map_q, map_d;
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic             overrun_q, overrun_d;
   logic             push_req, do_push, pop, clr, full, empty;
   logic [7:0]       push_byte, head;

   state_t           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [7:0]       resp_q, resp_d;
   logic             resp_valid_q, resp_valid_d;

   // p1: raw event capture; p2: registered table lookup
   always_comb begin
      vld_p1_d     = ps2_key[10];
      pressed_p1_d = ps2_key[9];
      key_p1_d     = ps2_key[8:0];
      lut_p1       = lookup(key_p1_q);
      vld_p2_d     = vld_p1_q & lut_p1[6];
      pressed_p2_d = pressed_p1_q;
      kc_p2_d      = lut_p1[5:0];
   end

   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign head      = fifo_mem[rd_ptr_q[AW-1:0]];
   assign push_byte = {~pressed_p2_q, kc_p2_q, 1'b1};

   // p2: repeat filter and FIFO push; a Model clear overrides everything here
   always_comb begin
      push_req = 1'b0;
      map_d    = map_q;
      if (vld_p2_q && (pressed_p2_q != map_q[kc_p2_q])) begin
         push_req        = 1'b1;
         map_d[kc_p2_q]  = pressed_p2_q;
      end
      do_push   = push_req && !clr && (!full || pop);
      overrun_d = overrun_q | (push_req && !clr && full && !pop);
      wr_ptr_d  = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      if (clr) begin
         map_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      cmd_d        = cmd_q;
      resp_d       = resp_q;
      resp_valid_d = 1'b0;
      pop          = 1'b0;
      clr          = 1'b0;
      case (state_q)
         H_IDLE: begin
            if (cmd_valid) begin
               cmd_d   = cmd;
               state_d = H_DECODE;
            end
         end
         H_DECODE: begin
            state_d      = H_REPLY;
            resp_valid_d = 1'b1;
            case (cmd_q)
               CMD_INQUIRY: begin
                  if (!empty) begin
                     pop    = 1'b1;
                     resp_d = head;
                  end else begin
                     timer_d      = '0;
                     state_d      = H_WAIT;
                     resp_valid_d = 1'b0;
                  end
               end
               CMD_INSTANT: begin
                  if (!empty) begin
                     pop    = 1'b1;
                     resp_d = head;
                  end else begin
                     resp_d = RESP_NULL;
                  end
               end
               CMD_MODEL: begin
                  resp_d = MODEL_BYTE;
                  clr    = 1'b1;
               end
               CMD_TEST: resp_d = RESP_ACK;
               default:  resp_d = RESP_NULL;
            endcase
         end
         H_WAIT: begin
            if (!empty) begin
               pop          = 1'b1;
               resp_d       = head;
               resp_valid_d = 1'b1;
               state_d      = H_REPLY;
            end else if (timer_q == TW'(INQ_TIMEOUT - 1)) begin
               resp_d       = RESP_NULL;
               resp_valid_d = 1'b1;
               state_d      = H_REPLY;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         H_REPLY: state_d = H_IDLE;
         default: state_d = H_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         map_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         vld_p1_q  <= vld_p1_d;
         vld_p2_q  <= vld_p2_d;
         map_q     <= map_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= H_IDLE;
         timer_q      <= '0;
         resp_q       <= 8'h00;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         resp_q       <= resp_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      key_p1_q     <= key_p1_d;
      pressed_p1_q <= pressed_p1_d;
      kc_p2_q      <= kc_p2_d;
      pressed_p2_q <= pressed_p2_d;
      cmd_q        <= cmd_d;
      if (do_push) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= push_byte;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp       = resp_q;
   assign busy       = (state_q != H_IDLE);
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_mac_key_queue.sv
// Scoreboard bench for mac_key_queue: expected transition codes are queued as
// keys are driven and compared against Instant/Inquiry replies.
module tb_mac_key_queue;
   localparam int DEPTH = 8;
   localparam int TO    = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] ps2_key;
   logic        cmd_valid;
   logic [7:0]  cmd;
   logic        resp_valid;
   logic [7:0]  resp;
   logic        busy;
   logic        overrun;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q [$];

   // A S D F H G Z X C and their make codes
   logic [7:0] sc_tab   [9] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h33, 8'h34, 8'h1A, 8'h22, 8'h21};
   logic [7:0] code_tab [9] = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h0D, 8'h0F, 8'h11};

   mac_key_queue #(.FIFO_DEPTH(DEPTH), .INQ_TIMEOUT(TO), .MODEL_BYTE(8'h03)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key), .cmd_valid(cmd_valid), .cmd(cmd),
      .resp_valid(resp_valid), .resp(resp), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_key(input logic pr, input logic ext, input logic [7:0] sc);
      @(negedge clk); ps2_key = {1'b1, pr, ext, sc};
      @(negedge clk); ps2_key = 11'h0;
   endtask

   task automatic send_cmd(input logic [7:0] c);
      @(negedge clk); cmd_valid = 1'b1; cmd = c;
      @(negedge clk); cmd_valid = 1'b0;
   endtask

   task automatic wait_resp(input int budget, output logic [7:0] got, output int lat);
      lat = -1;
      got = 8'hxx;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            got = resp;
            lat = n;
            break;
         end
      end
   endtask

   task automatic instant_round(output logic [7:0] got, output logic [7:0] want, output int lat);
      if (exp_q.size() != 0) want = exp_q.pop_front();
      else want = 8'h7B;
      send_cmd(8'h14);
      wait_resp(10, got, lat);
   endtask

   task automatic test_reset;
      logic [7:0] got, want;
      int lat;
      checks++;
      if (resp_valid !== 1'b0 || resp !== 8'h00 || busy !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL reset_state vld=%b resp=%h busy=%b ovr=%b, want 0 00 0 0", resp_valid, resp, busy, overrun);
      end
      instant_round(got, want, lat);
      checks++;
      if (got !== want || lat !== 1) begin
         failures++;
         $display("FAIL reset_instant resp=%h lat=%0d, want %h lat=1", got, lat, want);
      end
   endtask

   task automatic test_press_release;
      logic [7:0] got, want;
      int lat;
      send_key(1'b1, 1'b0, 8'h1C); exp_q.push_back(8'h01); idle(2);
      send_key(1'b0, 1'b0, 8'h1C); exp_q.push_back(8'h81); idle(3);
      for (int i = 0; i < 2; i++) begin
         instant_round(got, want, lat);
         checks++;
         if (got !== want || lat !== 1) begin
            failures++;
            $display("FAIL press_release[%0d] resp=%h lat=%0d, want %h lat=1", i, got, lat, want);
         end
      end
   endtask

   task automatic test_typematic;
      logic [7:0] got, want;
      int lat;
      for (int i = 0; i < 5; i++) begin
         send_key(1'b1, 1'b0, 8'h29);
         if (i == 0) exp_q.push_back(8'h63);
         idle(2);
      end
      send_key(1'b0, 1'b0, 8'h29); exp_q.push_back(8'hE3); idle(3);
      for (int i = 0; i < 3; i++) begin
         instant_round(got, want, lat);
         checks++;
         if (got !== want || lat !== 1) begin
            failures++;
            $display("FAIL typematic[%0d] resp=%h lat=%0d, want %h lat=1", i, got, lat, want);
         end
      end
   endtask

   task automatic test_translate;
      logic [7:0] got, want;
      int lat;
      send_key(1'b1, 1'b0, 8'h76); idle(2);
      send_key(1'b1, 1'b1, 8'h1C); idle(2);
      send_key(1'b1, 1'b0, 8'h1F); idle(2);
      send_key(1'b1, 1'b1, 8'h1F); exp_q.push_back(8'h6F); idle(2);
      send_key(1'b1, 1'b0, 8'h5A); exp_q.push_back(8'h49); idle(2);
      send_key(1'b0, 1'b1, 8'h1F); exp_q.push_back(8'hEF); idle(2);
      send_key(1'b0, 1'b0, 8'h5A); exp_q.push_back(8'hC9); idle(3);
      for (int i = 0; i < 5; i++) begin
         instant_round(got, want, lat);
         checks++;
         if (got !== want || lat !== 1) begin
            failures++;
            $display("FAIL translate[%0d] resp=%h lat=%0d, want %h lat=1", i, got, lat, want);
         end
      end
   endtask

   task automatic test_inquiry_key;
      logic [7:0] got, want;
      int lat;
      bit bad = 1'b0;
      send_cmd(8'h10);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy !== 1'b1 || resp_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL inquiry_busy busy=%b vld=%b during wait, want busy=1 vld=0", busy, resp_valid);
      end
      send_key(1'b1, 1'b0, 8'h29); exp_q.push_back(8'h63);
      want = exp_q.pop_front();
      wait_resp(20, got, lat);
      checks++;
      if (got !== want || lat !== 3) begin
         failures++;
         $display("FAIL inquiry_key resp=%h lat=%0d, want %h lat=3", got, lat, want);
      end
      send_key(1'b0, 1'b0, 8'h29); exp_q.push_back(8'hE3); idle(3);
      instant_round(got, want, lat);
      checks++;
      if (got !== want || lat !== 1) begin
         failures++;
         $display("FAIL inquiry_release resp=%h lat=%0d, want %h lat=1", got, lat, want);
      end
   endtask

   task automatic test_inquiry_timeout;
      logic [7:0] got;
      int lat = -1;
      bit extra = 1'b0;
      got = 8'hxx;
      send_cmd(8'h10);
      for (int n = 1; n <= TO + 20; n++) begin
         @(negedge clk);
         if (n == 500) begin cmd_valid = 1'b1; cmd = 8'h36; end
         else cmd_valid = 1'b0;
         if (resp_valid === 1'b1) begin
            got = resp;
            lat = n;
            break;
         end
      end
      cmd_valid = 1'b0;
      checks++;
      if (got !== 8'h7B || lat !== TO + 1) begin
         failures++;
         $display("FAIL inquiry_timeout resp=%h lat=%0d, want 7b lat=%0d", got, lat, TO + 1);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (resp_valid !== 1'b0 || busy !== 1'b0) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         failures++;
         $display("FAIL ignored_cmd vld=%b busy=%b after reply, want 0 0", resp_valid, busy);
      end
   endtask

   task automatic model_clear(input string tag);
      logic [7:0] got;
      int lat;
      exp_q.delete();
      send_cmd(8'h16);
      wait_resp(10, got, lat);
      checks++;
      if (got !== 8'h03 || lat !== 1) begin
         failures++;
         $display("FAIL model_%s resp=%h lat=%0d, want 03 lat=1", tag, got, lat);
      end
   endtask

   task automatic test_full_pop_push;
      logic [7:0] got, want;
      int lat;
      model_clear("full");
      for (int i = 0; i < 8; i++) begin
         send_key(1'b1, 1'b0, sc_tab[i]); exp_q.push_back(code_tab[i]); idle(2);
      end
      idle(2);
      @(negedge clk); ps2_key = {1'b1, 1'b1, 1'b0, sc_tab[8]}; exp_q.push_back(code_tab[8]);
      @(negedge clk); ps2_key = 11'h0; cmd_valid = 1'b1; cmd = 8'h14;
      @(negedge clk); cmd_valid = 1'b0;
      want = exp_q.pop_front();
      wait_resp(10, got, lat);
      checks++;
      if (got !== want || lat !== 1) begin
         failures++;
         $display("FAIL full_pop resp=%h lat=%0d, want %h lat=1", got, lat, want);
      end
      idle(3);
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL full_no_overrun overrun=%b, want 0", overrun);
      end
      for (int i = 0; i < 9; i++) begin
         instant_round(got, want, lat);
         checks++;
         if (got !== want || lat !== 1) begin
            failures++;
            $display("FAIL full_drain[%0d] resp=%h lat=%0d, want %h lat=1", i, got, lat, want);
         end
      end
   endtask

   task automatic test_overflow;
      logic [7:0] got, want;
      int lat;
      model_clear("overflow");
      for (int i = 0; i < 8; i++) begin
         send_key(1'b1, 1'b0, sc_tab[i]); exp_q.push_back(code_tab[i]); idle(2);
      end
      idle(2);
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_early overrun=%b, want 0", overrun);
      end
      send_key(1'b1, 1'b0, sc_tab[8]); idle(3);
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set overrun=%b, want 1", overrun);
      end
      for (int i = 0; i < 9; i++) begin
         instant_round(got, want, lat);
         checks++;
         if (got !== want || lat !== 1) begin
            failures++;
            $display("FAIL overflow_drain[%0d] resp=%h lat=%0d, want %h lat=1", i, got, lat, want);
         end
      end
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_sticky overrun=%b, want 1", overrun);
      end
   endtask

   task automatic test_model_race;
      logic [7:0] got, want;
      int lat;
      exp_q.delete();
      @(negedge clk); ps2_key = {1'b1, 1'b1, 1'b0, 8'h32};
      @(negedge clk); ps2_key = 11'h0; cmd_valid = 1'b1; cmd = 8'h16;
      @(negedge clk); cmd_valid = 1'b0;
      wait_resp(10, got, lat);
      checks++;
      if (got !== 8'h03 || lat !== 1) begin
         failures++;
         $display("FAIL model_race resp=%h lat=%0d, want 03 lat=1", got, lat);
      end
      idle(3);
      instant_round(got, want, lat);
      checks++;
      if (got !== want || lat !== 1) begin
         failures++;
         $display("FAIL model_race_empty resp=%h lat=%0d, want %h lat=1", got, lat, want);
      end
      send_key(1'b1, 1'b0, 8'h32); exp_q.push_back(8'h17); idle(3);
      instant_round(got, want, lat);
      checks++;
      if (got !== want || lat !== 1) begin
         failures++;
         $display("FAIL model_map_cleared resp=%h lat=%0d, want %h lat=1", got, lat, want);
      end
   endtask

   task automatic test_commands;
      logic [7:0] got;
      int lat;
      send_cmd(8'h36);
      wait_resp(10, got, lat);
      checks++;
      if (got !== 8'h7D || lat !== 1) begin
         failures++;
         $display("FAIL test_cmd resp=%h lat=%0d, want 7d lat=1", got, lat);
      end
      send_cmd(8'h55);
      wait_resp(10, got, lat);
      checks++;
      if (got !== 8'h7B || lat !== 1) begin
         failures++;
         $display("FAIL unknown_cmd resp=%h lat=%0d, want 7b lat=1", got, lat);
      end
   endtask

   task automatic test_reset_wait;
      bit seen = 1'b0;
      send_cmd(8'h10);
      idle(50);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL wait_busy busy=%b, want 1", busy);
      end
      @(negedge clk); rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || resp_valid !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL async_reset busy=%b vld=%b ovr=%b, want 0 0 0", busy, resp_valid, overrun);
      end
      idle(2);
      rst_n = 1'b1;
      for (int i = 0; i < TO + 20; i++) begin
         @(negedge clk);
         if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL reset_no_reply vld/busy activity after reset, want none");
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      ps2_key   = 11'h0;
      cmd_valid = 1'b0;
      cmd       = 8'h00;
      idle(3);
      rst_n = 1'b1;
      idle(1);
      test_reset();
      test_press_release();
      test_typematic();
      test_translate();
      test_inquiry_key();
      test_inquiry_timeout();
      test_full_pop_push();
      test_overflow();
      test_model_race();
      test_commands();
      test_reset_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
